fifo_read_ctrl: RTL and testbench
=================================

Name: fifo_read_ctrl

Overview:
Read-domain pointer and empty-flag controller for the interface async FIFO.
- Consumes the write pointer after it has been brought into r_clk through the gray-code pointer synchronizer.
- Produces the read-side gray pointer that the synchronizer carries back to the write domain.
- Generates the RAM read address, empty/almost-empty flags, occupancy level and a registered read-data/valid output.
- Sits between the dual-port RAM read port, the pointer synchronizer and the consumer.

Parameters:
FIFO_WIDTH, 8, data width in bits
FIFO_DEPTH_BIT, 4, log2 of FIFO depth; pointers are FIFO_DEPTH_BIT+1 bits wide
ALMOST_EMPTY_TH, 2, almost_empty asserts when level <= this value

Ports:
r_clk  input  1  read-domain clock; all logic on its rising edge
r_rst  input  1  reset, synchronous and active-high
read_en  input  1  consumer read request
write_addr_gray_sync  input  FIFO_DEPTH_BIT+1  write gray pointer, already synchronized to r_clk
mem_rdata  input  FIFO_WIDTH  RAM read-port data (combinational read of read_addr)
read_addr  output  FIFO_DEPTH_BIT  RAM read address = rptr_bin[FIFO_DEPTH_BIT-1:0]
read_addr_gray  output  FIFO_DEPTH_BIT+1  registered gray read pointer, goes to synchronizer
read_data  output  FIFO_WIDTH  registered read data
read_valid  output  1  read_data valid, one-cycle pulse per accepted read
empty  output  1  registered empty flag
almost_empty  output  1  registered, level <= ALMOST_EMPTY_TH
r_level  output  FIFO_DEPTH_BIT+1  registered occupancy, 0..2^FIFO_DEPTH_BIT
underflow  output  1  one-cycle pulse, read_en while empty

Behaviour:
- Reset (r_rst=1 at r_clk edge):
  - rptr_bin=0, read_addr_gray=0, read_addr=0.
  - empty=1, almost_empty=1, r_level=0.
  - read_valid=0, read_data=0, underflow=0.
  - Reset asserted mid-operation overrides every other action in that cycle. After reset is released, the block recomputes its state from write_addr_gray_sync on the next edge.
- Read acceptance:
  - Accept when read_en & ~empty, using the registered empty.
  - rptr_next = rptr_bin + accept, modulo 2^(FIFO_DEPTH_BIT+1). The pointer wraps from all-ones to 0; the MSB toggles every pass.
- Gray conversion:
  - read_addr_gray <= rptr_next ^ (rptr_next >> 1), registered.
  - Only one bit may change per cycle.
- Write pointer decode:
  - wbin = gray-to-binary of write_addr_gray_sync, computed combinationally.
  - wbin[i] = XOR of gray bits i..MSB.
- Level and flags, all registered from next-state values:
  - r_level <= wbin - rptr_next, modulo 2^(FIFO_DEPTH_BIT+1).
  - empty <= (rptr_next gray == write_addr_gray_sync).
  - almost_empty <= (wbin - rptr_next) <= ALMOST_EMPTY_TH.
  - empty and r_level==0 are always consistent.
- Data path:
  - On an accepted read, read_data <= mem_rdata (data at the current read_addr) and read_valid <= 1. Latency is one cycle from accept.
  - Otherwise read_valid <= 0 and read_data holds its value.
- Underflow:
  - underflow <= read_en & empty.
  - The pointer does not move and read_valid stays 0.
- Back-to-back reads:
  - Read every cycle while not empty.
  - The last entry drains with empty rising the edge after the final accept. No extra read is accepted.
- Simultaneous write arrival and read:
  - A new write_addr_gray_sync and an accept in the same cycle are both reflected in that edge's r_level and empty.
- Full level:
  - r_level = 2^FIFO_DEPTH_BIT is legal; its MSB is set.
- Pessimism:
  - empty may stay asserted for synchronizer latency after a write. This is intended.
  - empty never deasserts early.

Test Plan:
1. Reset: hold r_rst 2 cycles with write_addr_gray_sync=5'b00011 -> all outputs 0 except empty=1 and almost_empty=1. One cycle after release: r_level=2, empty=0, almost_empty=1.
2. Underflow: empty FIFO, read_en=1 for 3 cycles -> underflow=1 for 3 cycles, read_valid=0, read_addr_gray stays 0.
3. Drain: write pointer gray for bin 4 (5'b00110), read_en held -> 4 read_valid pulses, read_data = mem_rdata at addr 0,1,2,3. r_level goes 4,3,2,1,0. empty rises on the edge after the 4th accept.
4. Wrap: preload rptr_bin=30 and wbin=2 (gray 5'b00011) -> r_level=4. Four reads give read_addr 14,15,0,1 and read_addr_gray 5'b10001, 5'b10000, 5'b00000, 5'b00001, then empty=1.
5. Simultaneous: r_level=1 with read accepted while the sync pointer advances by 1 -> r_level stays 1, empty stays 0.
6. Full: wbin=16 (gray 5'b11000), rptr 0 -> r_level=16, empty=0, almost_empty=0. Reset asserted mid-drain -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-domain pointer, empty-flag and data-output controller for the async FIFO.
// Consumes the synchronized write gray pointer and produces the read gray pointer.
module fifo_read_ctrl #(
    parameter int FIFO_WIDTH      = 8,
    parameter int FIFO_DEPTH_BIT  = 4,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                      r_clk,
    input  logic                      r_rst,
    input  logic                      read_en,
    input  logic [FIFO_DEPTH_BIT:0]   write_addr_gray_sync,
    input  logic [FIFO_WIDTH-1:0]     mem_rdata,
    output logic [FIFO_DEPTH_BIT-1:0] read_addr,
    output logic [FIFO_DEPTH_BIT:0]   read_addr_gray,
    output logic [FIFO_WIDTH-1:0]     read_data,
    output logic                      read_valid,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [FIFO_DEPTH_BIT:0]   r_level,
    output logic                      underflow
);

    localparam int PW = FIFO_DEPTH_BIT + 1;
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         gray_q, gray_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  empty_q, empty_d;
    logic                  ae_q, ae_d;
    logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  under_q, under_d;

    logic                  accept;
    logic [PW-1:0]         wbin;

    // Gray-to-binary decode of the synchronized write pointer.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(write_addr_gray_sync >> i);
        end
    end

    // Next-state pointer, flags, level and data capture.
    always_comb begin
        accept   = read_en & ~empty_q;
        rptr_d   = rptr_q + {{(PW-1){1'b0}}, accept};
        gray_d   = rptr_d ^ (rptr_d >> 1);
        level_d  = wbin - rptr_d;
        empty_d  = (gray_d == write_addr_gray_sync);
        ae_d     = (level_d <= AE_TH);
        rvalid_d = accept;
        rdata_d  = accept ? mem_rdata : rdata_q;
        under_d  = read_en & empty_q;
    end

    // State registers; reset overrides every other action in the cycle.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rptr_q   <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            under_q  <= under_d;
        end
    end

    assign read_addr      = rptr_q[FIFO_DEPTH_BIT-1:0];
    assign read_addr_gray = gray_q;
    assign read_data      = rdata_q;
    assign read_valid     = rvalid_q;
    assign empty          = empty_q;
    assign almost_empty   = ae_q;
    assign r_level        = level_q;
    assign underflow      = under_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl with a behavioural RAM
// and a scoreboard queue of expected read data.
module tb_fifo_read_ctrl;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       read_en;
    logic [4:0] write_addr_gray_sync;
    logic [7:0] mem_rdata;
    logic [3:0] read_addr;
    logic [4:0] read_addr_gray;
    logic [7:0] read_data;
    logic       read_valid;
    logic       empty;
    logic       almost_empty;
    logic [4:0] r_level;
    logic       underflow;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    logic [4:0] m_rptr;
    logic       m_empty;
    int n_cmp = 0;
    int n_err = 0;

    always #5 r_clk = ~r_clk;

    assign mem_rdata = mem[read_addr];

    fifo_read_ctrl #(
        .FIFO_WIDTH(8),
        .FIFO_DEPTH_BIT(4),
        .ALMOST_EMPTY_TH(2)
    ) dut (
        .r_clk(r_clk),
        .r_rst(r_rst),
        .read_en(read_en),
        .write_addr_gray_sync(write_addr_gray_sync),
        .mem_rdata(mem_rdata),
        .read_addr(read_addr),
        .read_addr_gray(read_addr_gray),
        .read_data(read_data),
        .read_valid(read_valid),
        .empty(empty),
        .almost_empty(almost_empty),
        .r_level(r_level),
        .underflow(underflow)
    );

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // One clock: drive inputs, update the reference model, push expected data.
    task automatic cycle(input logic ren, input logic [4:0] wb, input logic rst);
        logic acc;
        read_en = ren;
        write_addr_gray_sync = b2g(wb);
        r_rst = rst;
        acc = ren & ~m_empty & ~rst;
        if (acc) exp_q.push_back(mem[m_rptr[3:0]]);
        if (rst) begin
            m_rptr = '0;
            m_empty = 1'b1;
        end else begin
            m_rptr = m_rptr + {4'd0, acc};
            m_empty = (wb == m_rptr);
        end
        @(posedge r_clk);
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b0, 5'd2, 1'b1);
        cycle(1'b0, 5'd2, 1'b1);
        n_cmp++;
        if ({read_addr, read_addr_gray, read_data, read_valid, r_level, underflow} !== '0) begin
            n_err++;
            $display("FAIL reset_zero: addr=%0d gray=%b data=%h v=%b lvl=%0d uf=%b expected all 0",
                     read_addr, read_addr_gray, read_data, read_valid, r_level, underflow);
        end
        n_cmp++;
        if ({empty, almost_empty} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_flags: empty=%b ae=%b expected 1 1", empty, almost_empty);
        end
        cycle(1'b0, 5'd2, 1'b0);
        n_cmp++;
        if ({r_level, empty, almost_empty} !== {5'd2, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_release: lvl=%0d empty=%b ae=%b expected 2 0 1",
                     r_level, empty, almost_empty);
        end
        cycle(1'b0, 5'd0, 1'b1);
        cycle(1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_underflow;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd0, 1'b0);
            n_cmp++;
            if ({underflow, read_valid, read_addr_gray} !== {1'b1, 1'b0, 5'd0}) begin
                n_err++;
                $display("FAIL underflow_%0d: uf=%b v=%b gray=%b expected 1 0 00000",
                         i, underflow, read_valid, read_addr_gray);
            end
        end
        cycle(1'b0, 5'd0, 1'b0);
        n_cmp++;
        if (underflow !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_clear: uf=%b expected 0", underflow);
        end
    endtask

    task automatic test_drain;
        logic [7:0] e;
        cycle(1'b0, 5'd4, 1'b0);
        n_cmp++;
        if ({r_level, empty} !== {5'd4, 1'b0}) begin
            n_err++;
            $display("FAIL drain_start: lvl=%0d empty=%b expected 4 0", r_level, empty);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (read_addr !== 4'(i)) begin
                n_err++;
                $display("FAIL drain_addr_%0d: addr=%0d expected %0d", i, read_addr, i);
            end
            cycle(1'b1, 5'd4, 1'b0);
            n_cmp++;
            if ({read_valid, r_level, empty} !== {1'b1, 5'(3 - i), (i == 3)}) begin
                n_err++;
                $display("FAIL drain_step_%0d: v=%b lvl=%0d empty=%b expected 1 %0d %0d",
                         i, read_valid, r_level, empty, 3 - i, i == 3);
            end
            if (read_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (read_data !== e) begin
                    n_err++;
                    $display("FAIL drain_data_%0d: data=%h expected %h", i, read_data, e);
                end
            end
        end
        cycle(1'b1, 5'd4, 1'b0);
        n_cmp++;
        if ({read_valid, underflow, read_addr} !== {1'b0, 1'b1, 4'd4}) begin
            n_err++;
            $display("FAIL drain_extra: v=%b uf=%b addr=%0d expected 0 1 4",
                     read_valid, underflow, read_addr);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] e;
        logic [3:0] addr_tab [4];
        logic [4:0] gray_tab [4];
        int guard;
        addr_tab = '{4'd14, 4'd15, 4'd0, 4'd1};
        gray_tab = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};
        guard = 0;
        while (m_rptr != 5'd30 && guard < 200) begin
            cycle(1'b1, m_rptr + 5'd3, 1'b0);
            guard++;
            if (read_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (read_data !== e) begin
                    n_err++;
                    $display("FAIL advance_data: data=%h expected %h", read_data, e);
                end
            end
        end
        n_cmp++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL wrap_timeout: rptr=%0d expected 30", m_rptr);
        end
        cycle(1'b0, 5'd2, 1'b0);
        n_cmp++;
        if ({r_level, empty} !== {5'd4, 1'b0}) begin
            n_err++;
            $display("FAIL wrap_level: lvl=%0d empty=%b expected 4 0", r_level, empty);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({read_addr, read_addr_gray} !== {addr_tab[i], gray_tab[i]}) begin
                n_err++;
                $display("FAIL wrap_ptr_%0d: addr=%0d gray=%b expected %0d %b",
                         i, read_addr, read_addr_gray, addr_tab[i], gray_tab[i]);
            end
            cycle(1'b1, 5'd2, 1'b0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({read_valid, read_data} !== {1'b1, e}) begin
                    n_err++;
                    $display("FAIL wrap_data_%0d: v=%b data=%h expected 1 %h",
                             i, read_valid, read_data, e);
                end
            end
        end
        n_cmp++;
        if ({empty, read_addr_gray, r_level} !== {1'b1, 5'b00011, 5'd0}) begin
            n_err++;
            $display("FAIL wrap_end: empty=%b gray=%b lvl=%0d expected 1 00011 0",
                     empty, read_addr_gray, r_level);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] e;
        cycle(1'b0, 5'd3, 1'b0);
        n_cmp++;
        if ({r_level, empty} !== {5'd1, 1'b0}) begin
            n_err++;
            $display("FAIL simul_pre: lvl=%0d empty=%b expected 1 0", r_level, empty);
        end
        cycle(1'b1, 5'd4, 1'b0);
        n_cmp++;
        if ({r_level, empty, read_valid} !== {5'd1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL simul: lvl=%0d empty=%b v=%b expected 1 0 1",
                     r_level, empty, read_valid);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (read_data !== e) begin
                n_err++;
                $display("FAIL simul_data: data=%h expected %h", read_data, e);
            end
        end
    endtask

    task automatic test_full;
        logic [7:0] e;
        cycle(1'b0, 5'd0, 1'b1);
        cycle(1'b0, 5'd16, 1'b0);
        n_cmp++;
        if ({r_level, empty, almost_empty} !== {5'd16, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL full: lvl=%0d empty=%b ae=%b expected 16 0 0",
                     r_level, empty, almost_empty);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 5'd16, 1'b0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({read_valid, read_data, r_level} !== {1'b1, e, 5'(15 - i)}) begin
                    n_err++;
                    $display("FAIL full_drain_%0d: v=%b data=%h lvl=%0d expected 1 %h %0d",
                             i, read_valid, read_data, r_level, e, 15 - i);
                end
            end
        end
        cycle(1'b1, 5'd16, 1'b1);
        n_cmp++;
        if ({read_addr, read_addr_gray, read_data, read_valid, r_level, underflow,
             empty, almost_empty} !== {4'd0, 5'd0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset: addr=%0d gray=%b data=%h v=%b lvl=%0d uf=%b e=%b ae=%b expected reset values",
                     read_addr, read_addr_gray, read_data, read_valid, r_level, underflow,
                     empty, almost_empty);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(1, 255));
        r_rst = 1'b1;
        read_en = 1'b0;
        write_addr_gray_sync = '0;
        m_rptr = '0;
        m_empty = 1'b1;
        @(negedge r_clk);
        test_reset;
        test_underflow;
        test_drain;
        test_wrap;
        test_simultaneous;
        test_full;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
